// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared bus widths, buffer sizing and the stored entry layout
package store_buffer_pkg;
    localparam int REG_BUS       = 32;
    localparam int DATA_ADDR_BUS = 32;
    localparam int SB_DEPTH      = 4;
    localparam int SB_STARVE_MAX = 8;

    typedef struct packed {
        logic [DATA_ADDR_BUS-1:0] addr;
        logic [3:0]               sel;
        logic [REG_BUS-1:0]       data;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_sb_fifo.sv
// sb_fifo: ring of posted stores with occupancy tracking and parallel word-address hit detection
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_i,
    input  logic                     deq_i,
    input  sb_entry_t                entry_i,
    input  logic [DATA_ADDR_BUS-3:0] cmp_word_i,
    output sb_entry_t                head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     hit_o
);
    localparam int PW = $clog2(DEPTH);

    sb_entry_t        mem_q [DEPTH];
    sb_entry_t        mem_d [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PW:0]      count_q, count_d;
    logic [DEPTH-1:0] match;

    // An entry is live when its distance from head is below the occupancy
    always_comb begin
        mem_d = mem_q;
        if (enq_i) mem_d[tail_q] = entry_i;
        head_d  = head_q + PW'(deq_i);
        tail_d  = tail_q + PW'(enq_i);
        count_d = count_q + (PW+1)'(enq_i) - (PW+1)'(deq_i);
        match   = '0;
        for (int i = 0; i < DEPTH; i++)
            match[i] = ({1'b0, PW'(i) - head_q} < count_q) &&
                       (mem_q[i].addr[DATA_ADDR_BUS-1:2] == cmp_word_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    assign head_o  = mem_q[head_q];
    assign full_o  = count_q == (PW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign hit_o   = |match;
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer arbitrating one memory port between load pass-through and store drain
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH      = SB_DEPTH,
    parameter int STARVE_MAX = SB_STARVE_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_ce_i,
    input  logic                     cpu_we_i,
    input  logic [DATA_ADDR_BUS-1:0] cpu_addr_i,
    input  logic [3:0]               cpu_sel_i,
    input  logic [REG_BUS-1:0]       cpu_data_i,
    output logic [REG_BUS-1:0]       cpu_data_o,
    input  logic                     fence_i,
    output logic                     stall_o,
    output logic                     empty_o,
    output logic                     ram_ce_o,
    output logic                     ram_we_o,
    output logic [DATA_ADDR_BUS-1:0] ram_addr_o,
    output logic [3:0]               ram_sel_o,
    output logic [REG_BUS-1:0]       ram_data_o,
    input  logic [REG_BUS-1:0]       ram_data_i
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;
    logic          load, store, hit, full, empty, force_drain, fence_hold, pass, drain, enq;
    sb_entry_t     head;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .enq_i      (enq),
        .deq_i      (drain),
        .entry_i    ({cpu_addr_i, cpu_sel_i, cpu_data_i}),
        .cmp_word_i (cpu_addr_i[DATA_ADDR_BUS-1:2]),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty),
        .hit_o      (hit)
    );

    // Requests are masked while reset is held so the port stays quiet
    always_comb begin
        load        = rst && cpu_ce_i && !cpu_we_i;
        store       = rst && cpu_ce_i && cpu_we_i;
        fence_hold  = rst && fence_i && !empty;
        force_drain = !empty && (starve_q == SW'(STARVE_MAX));
        pass        = load && !hit && !force_drain && !fence_hold;
        drain       = !empty && !pass;
        stall_o     = fence_hold || (load && !pass) || (store && full);
        enq         = store && !stall_o;
        starve_d    = drain ? '0 : (pass && !empty) ? starve_q + 1'b1 : starve_q;
        empty_o     = empty;
        ram_ce_o    = pass || drain;
        ram_we_o    = drain;
        ram_addr_o  = drain ? head.addr : pass ? cpu_addr_i : '0;
        ram_sel_o   = drain ? head.sel : pass ? cpu_sel_i : '0;
        ram_data_o  = drain ? head.data : '0;
        cpu_data_o  = pass ? ram_data_i : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_q <= '0;
        else      starve_q <= starve_d;
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: vector table, directed corner sequences and randomized queue-model check of store_buffer
module tb_store_buffer;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_ce_i, cpu_we_i, fence_i;
    logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
    logic [3:0]  cpu_sel_i;
    logic        stall_o, empty_o, ram_ce_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
    logic [3:0]  ram_sel_o;

    logic        init_req = 1'b1;
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] wlog [$];
    int          total = 0;
    int          bad = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } st_t;
    st_t q [$];
    int  starve = 0;

    logic        s_stall, s_ce, s_we, s_empty;
    logic [31:0] s_addr, s_rd;

    typedef struct {
        logic        ce, we, f;
        logic [31:0] a, d;
        logic        e_stall, e_ce, e_we, e_empty, chk_rd;
        logic [31:0] e_addr, e_rd;
    } vec_t;
    vec_t tbl [15];

    store_buffer #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .fence_i    (fence_i),
        .stall_o    (stall_o),
        .empty_o    (empty_o),
        .ram_ce_o   (ram_ce_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_sel_o  (ram_sel_o),
        .ram_data_o (ram_data_o),
        .ram_data_i (ram_data_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    // Combinational-read memory behind the port; logs every write address
    assign ram_data_i = mem[ram_addr_o[11:2]];
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (ram_ce_o && ram_we_o) begin
            mem[ram_addr_o[11:2]] <= merge(mem[ram_addr_o[11:2]], ram_data_o, ram_sel_o);
            wlog.push_back(ram_addr_o);
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    // One CPU cycle: drive, predict from the pending-store queue, compare, then advance the model
    task automatic step(input logic ce, input logic we, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic f);
        logic hit, ld, st, fh, frc, pl, dr, es;
        cpu_ce_i = ce; cpu_we_i = we; cpu_addr_i = a; cpu_sel_i = s; cpu_data_i = d; fence_i = f;
        ld  = ce && !we;
        st  = ce && we;
        hit = 1'b0;
        foreach (q[i]) if (q[i].a[31:2] == a[31:2]) hit = 1'b1;
        fh  = f && q.size() != 0;
        frc = q.size() != 0 && starve == STARVE_MAX;
        pl  = ld && !hit && !frc && !fh;
        dr  = q.size() != 0 && !pl;
        es  = fh || (ld && !pl) || (st && q.size() == DEPTH);
        #3;
        s_stall = stall_o; s_ce = ram_ce_o; s_we = ram_we_o; s_empty = empty_o;
        s_addr = ram_addr_o; s_rd = cpu_data_o;
        check("stall", 32'(stall_o), 32'(es));
        check("empty", 32'(empty_o), 32'(q.size() == 0));
        check("ram_ce", 32'(ram_ce_o), 32'(pl || dr));
        check("ram_we", 32'(ram_we_o), 32'(dr));
        if (dr) begin
            check("drain_addr", ram_addr_o, q[0].a);
            check("drain_sel", 32'(ram_sel_o), 32'(q[0].s));
            check("drain_data", ram_data_o, q[0].d);
        end
        if (pl) begin
            check("load_addr", ram_addr_o, a);
            check("load_data", cpu_data_o, ref_mem[a[11:2]]);
        end
        if (!ce && q.size() == 0) check("idle_data", cpu_data_o, 32'h0);
        if (dr) begin
            ref_mem[q[0].a[11:2]] = merge(ref_mem[q[0].a[11:2]], q[0].d, q[0].s);
            void'(q.pop_front());
            starve = 0;
        end else if (pl && q.size() != 0) starve++;
        if (st && !es) q.push_back('{a: a, s: s, d: d});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          n0, mm, r, heavy;
        logic        ce, we, f;
        logic [31:0] a, d;
        logic [3:0]  s;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        tbl[0]  = '{Y, Y, N, 32'h200, 32'hDEADBEEF, N, N, N, Y, N, 32'h0,   32'h0};
        tbl[1]  = '{Y, N, N, 32'h200, 32'h0,        Y, Y, Y, N, N, 32'h200, 32'h0};
        tbl[2]  = '{Y, N, N, 32'h200, 32'h0,        N, Y, N, Y, Y, 32'h200, 32'hDEADBEEF};
        tbl[3]  = '{Y, Y, N, 32'h100, 32'h11111111, N, N, N, Y, N, 32'h0,   32'h0};
        tbl[4]  = '{Y, Y, N, 32'h104, 32'h22222222, N, Y, Y, N, N, 32'h100, 32'h0};
        tbl[5]  = '{Y, Y, N, 32'h108, 32'h33333333, N, Y, Y, N, N, 32'h104, 32'h0};
        tbl[6]  = '{Y, Y, N, 32'h10C, 32'h44444444, N, Y, Y, N, N, 32'h108, 32'h0};
        tbl[7]  = '{N, N, N, 32'h0,   32'h0,        N, Y, Y, N, N, 32'h10C, 32'h0};
        tbl[8]  = '{N, N, N, 32'h0,   32'h0,        N, N, N, Y, Y, 32'h0,   32'h0};
        tbl[9]  = '{Y, Y, N, 32'h110, 32'h55555555, N, N, N, Y, N, 32'h0,   32'h0};
        tbl[10] = '{Y, Y, N, 32'h114, 32'h66666666, N, Y, Y, N, N, 32'h110, 32'h0};
        tbl[11] = '{Y, Y, N, 32'h118, 32'h77777777, N, Y, Y, N, N, 32'h114, 32'h0};
        tbl[12] = '{Y, N, Y, 32'h500, 32'h0,        Y, Y, Y, N, N, 32'h118, 32'h0};
        tbl[13] = '{Y, N, Y, 32'h500, 32'h0,        N, Y, N, Y, Y, 32'h500, 32'hC0DE0140};
        tbl[14] = '{Y, N, N, 32'h104, 32'h0,        N, Y, N, Y, Y, 32'h104, 32'h22222222};

        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100; cpu_sel_i = 4'hF;
        cpu_data_i = 32'h0; fence_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        init_req = 1'b0;
        check("rst_empty", 32'(empty_o), 32'h1);
        check("rst_ram_ce", 32'(ram_ce_o), 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_cpu_data", cpu_data_o, 32'h0);
        cpu_ce_i = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].ce, tbl[i].we, tbl[i].a, 4'hF, tbl[i].d, tbl[i].f);
            check($sformatf("v%0d_stall", i), 32'(s_stall), 32'(tbl[i].e_stall));
            check($sformatf("v%0d_ce", i), 32'(s_ce), 32'(tbl[i].e_ce));
            check($sformatf("v%0d_we", i), 32'(s_we), 32'(tbl[i].e_we));
            check($sformatf("v%0d_empty", i), 32'(s_empty), 32'(tbl[i].e_empty));
            if (tbl[i].e_ce) check($sformatf("v%0d_addr", i), s_addr, tbl[i].e_addr);
            if (tbl[i].chk_rd) check($sformatf("v%0d_rd", i), s_rd, tbl[i].e_rd);
        end

        n0 = wlog.size();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 32'h120 + 32'(4 * k), 4'hF, 32'hA000_0000 + 32'(k), 1'b0);
            check("t3_stall", 32'(s_stall), 32'h0);
        end
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        check("t3_nwrites", 32'(wlog.size() - n0), 32'd5);
        for (int k = 0; k < 5; k++)
            if (n0 + k < wlog.size()) check($sformatf("t3_order%0d", k), wlog[n0 + k], 32'h120 + 32'(4 * k));

        step(1'b1, 1'b1, 32'h300, 4'hF, 32'h0BADF00D, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            step(1'b1, 1'b0, 32'h400, 4'hF, 32'h0, 1'b0);
            check($sformatf("t5_stall%0d", k), 32'(s_stall), 32'(k == 9));
            check($sformatf("t5_we%0d", k), 32'(s_we), 32'(k == 9));
        end

        step(1'b1, 1'b1, 32'h140, 4'hF, 32'h12345678, 1'b0);
        cpu_ce_i = 1'b0;
        #2;
        check("t1_pre_ce", 32'(ram_ce_o), 32'h1);
        n0 = wlog.size();
        rst = 1'b0;
        #1;
        check("t1_empty", 32'(empty_o), 32'h1);
        check("t1_ram_ce", 32'(ram_ce_o), 32'h0);
        check("t1_stall", 32'(stall_o), 32'h0);
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h140;
        #1;
        check("t1_ld_ce", 32'(ram_ce_o), 32'h0);
        check("t1_ld_data", cpu_data_o, 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        cpu_ce_i = 1'b0;
        q.delete();
        starve = 0;
        @(posedge clk);
        #1;
        repeat (3) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        check("t1_no_write", 32'(wlog.size() - n0), 32'h0);
        check("t1_mem", mem[32'h50], 32'hC0DE0050);

        ce = 1'b0; we = 1'b0; f = 1'b0; a = 32'h0; d = 32'h0; s = 4'h0; heavy = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 50 == 0) heavy = int'($urandom_range(0, 1));
            if (!s_stall) begin
                r  = int'($urandom_range(0, 99));
                ce = r < 85;
                we = (heavy != 0) ? (r < 8) : (r < 40);
                f  = $urandom_range(0, 9) == 0;
                a  = (($urandom_range(0, 3) == 0) ? 32'h600 : 32'h100) +
                     32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
                s  = 4'($urandom_range(1, 15));
                d  = $urandom;
            end
            step(ce, we, a, s, d, f);
        end
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        check("final_empty", 32'(empty_o), 32'h1);
        mm = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mm++;
        check("mem_image", 32'(mm), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
